// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel: input capture, transition minimisation, DC balance.
// Define TMDS_INPUT_REG_EN to add one extra input register stage (latency 2 -> 3 cycles).
module tmds_channel_encoder (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] tmds_out,
    output logic [4:0] disparity
);

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // q_m[8] flags the XOR chain; XNOR is chosen when it yields fewer transitions
    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic [7:0] w_src_data;
    logic [1:0] w_src_c;
    logic       w_src_de;

`ifdef TMDS_INPUT_REG_EN
    logic [7:0] r_in_data;
    logic [1:0] r_in_c;
    logic       r_in_de;

    // optional input retiming register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_in_data <= 8'h00;
            r_in_c    <= 2'b00;
            r_in_de   <= 1'b0;
        end else begin
            r_in_data <= data;
            r_in_c    <= {c1, c0};
            r_in_de   <= de;
        end
    end

    assign w_src_data = r_in_data;
    assign w_src_c    = r_in_c;
    assign w_src_de   = r_in_de;
`else
    assign w_src_data = data;
    assign w_src_c    = {c1, c0};
    assign w_src_de   = de;
`endif

    logic [7:0] r_s1_data;
    logic [1:0] r_s1_c;
    logic       r_s1_de;
    logic [8:0] r_qm;
    logic [1:0] r_s2_c;
    logic       r_s2_de;

    // stage 1 capture, then transition-minimised word registered alongside its controls
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_s1_data <= 8'h00;
            r_s1_c    <= 2'b00;
            r_s1_de   <= 1'b0;
            r_qm      <= 9'h000;
            r_s2_c    <= 2'b00;
            r_s2_de   <= 1'b0;
        end else begin
            r_s1_data <= w_src_data;
            r_s1_c    <= w_src_c;
            r_s1_de   <= w_src_de;
            r_qm      <= transition_min(r_s1_data);
            r_s2_c    <= r_s1_c;
            r_s2_de   <= r_s1_de;
        end
    end

    logic [9:0] r_tmds;
    logic [4:0] r_cnt;
    logic [3:0] w_n1q;
    logic [4:0] w_diff;
    logic       w_cnt_pos;
    logic       w_cnt_neg;
    logic [9:0] w_next_tmds;
    logic [4:0] w_next_cnt;

    assign w_n1q     = popcount8(r_qm[7:0]);
    assign w_diff    = {w_n1q, 1'b0} - 5'd8;
    assign w_cnt_neg = r_cnt[4];
    assign w_cnt_pos = ~r_cnt[4] && (r_cnt != 5'd0);

    // DC balance selection and running-disparity update; blanking emits a token and clears cnt
    always_comb begin
        w_next_tmds = CTRL_00;
        w_next_cnt  = 5'd0;
        if (!r_s2_de) begin
            case (r_s2_c)
                2'b00:   w_next_tmds = CTRL_00;
                2'b01:   w_next_tmds = CTRL_01;
                2'b10:   w_next_tmds = CTRL_10;
                2'b11:   w_next_tmds = CTRL_11;
                default: w_next_tmds = CTRL_00;
            endcase
            w_next_cnt = 5'd0;
        end else if ((r_cnt == 5'd0) || (w_n1q == 4'd4)) begin
            w_next_tmds = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
            w_next_cnt  = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((w_cnt_pos && (w_n1q > 4'd4)) || (w_cnt_neg && (w_n1q < 4'd4))) begin
            w_next_tmds = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_next_cnt  = r_cnt + {3'b000, r_qm[8], 1'b0} - w_diff;
        end else begin
            w_next_tmds = {1'b0, r_qm[8], r_qm[7:0]};
            w_next_cnt  = r_cnt - {3'b000, ~r_qm[8], 1'b0} + w_diff;
        end
    end

    // output symbol and running disparity registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_tmds <= CTRL_00;
            r_cnt  <= 5'd0;
        end else begin
            r_tmds <= w_next_tmds;
            r_cnt  <= w_next_cnt;
        end
    end

    assign tmds_out  = r_tmds;
    assign disparity = r_cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: directed cases plus randomized stream vs a
// queue-based reference model built from the TMDS encoding rules.
module tb_tmds_channel_encoder;

`ifdef TMDS_INPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic       de = 1'b0;
    logic [9:0] tmds_out;
    logic [4:0] disparity;

    tmds_channel_encoder dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .data      (data),
        .c0        (c0),
        .c1        (c1),
        .de        (de),
        .tmds_out  (tmds_out),
        .disparity (disparity)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int       tmds;
        int       disp;
        bit       is_data;
        bit [7:0] d;
    } sym_t;

    sym_t pipe_q[$];
    int   mcnt;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tokens[4];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic bit [7:0] decode(input bit [9:0] s);
        bit [7:0] q;
        bit [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // reference encoder: plain integer arithmetic on the running disparity mcnt
    task automatic model_encode(input bit [7:0] d, input bit [1:0] c, input bit e, output sym_t s);
        int n1, n1q, n0q;
        bit use_xnor;
        bit [8:0] qm;
        s.d = d;
        s.is_data = e;
        if (!e) begin
            s.tmds = tokens[c];
            mcnt = 0;
        end else begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += d[i];
            use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !use_xnor;
            n1q = 0;
            for (int i = 0; i < 8; i++) n1q += qm[i];
            n0q = 8 - n1q;
            if (mcnt == 0 || n1q == n0q) begin
                s.tmds = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                mcnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
            end else if ((mcnt > 0 && n1q > n0q) || (mcnt < 0 && n0q > n1q)) begin
                s.tmds = {1'b1, qm[8], ~qm[7:0]};
                mcnt += 2 * qm[8] + (n0q - n1q);
            end else begin
                s.tmds = {1'b0, qm[8], qm[7:0]};
                mcnt += -2 * (qm[8] ? 0 : 1) + (n1q - n0q);
            end
        end
        s.disp = mcnt;
    endtask

    task automatic step(input bit [7:0] d, input bit [1:0] c, input bit e, input bit r);
        sym_t s, expv;
        data = d;
        {c1, c0} = c;
        de = e;
        reset = r;
        @(posedge clk_pixel);
        #1;
        if (r) begin
            pipe_q.delete();
            mcnt = 0;
            expv = '{tmds: 'h354, disp: 0, is_data: 1'b0, d: 8'h00};
            for (int i = 0; i < LAT; i++) pipe_q.push_back(expv);
        end else begin
            model_encode(d, c, e, s);
            pipe_q.push_back(s);
            expv = pipe_q.pop_front();
        end
        check_eq("tmds", {22'd0, tmds_out}, expv.tmds);
        check_eq("disp", {{27{disparity[4]}}, disparity}, expv.disp);
        check_eq("disp_bound", ($signed(disparity) <= 5'sd10 && $signed(disparity) >= -5'sd10), 1);
        if (expv.is_data) check_eq("decode", {24'd0, decode(tmds_out)}, {24'd0, expv.d});
        else check_eq("blank_disp0", {27'd0, disparity}, 0);
    endtask

    initial begin
        tokens[0] = 'h354;
        tokens[1] = 'h0AB;
        tokens[2] = 'h154;
        tokens[3] = 'h2AB;
        mcnt = 0;

        // reset held with active video on the inputs
        for (int k = 0; k < 4; k++) begin
            step(8'hA5, 2'b00, 1'b1, 1'b1);
            check_eq("rst_tmds", {22'd0, tmds_out}, 'h354);
            check_eq("rst_disp", {27'd0, disparity}, 0);
        end
        for (int k = 0; k <= LAT; k++) begin
            step(8'hA5, 2'b00, 1'b1, 1'b0);
            if (k < LAT) check_eq("rel_idle", {22'd0, tmds_out}, 'h354);
            else check_eq("rel_first", {22'd0, tmds_out}, 'h163);
        end

        // control tokens
        for (int k = 0; k < LAT + 2; k++) step(8'h00, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 4 + LAT; k++) begin
            step(8'h00, (k < 4) ? 2'(k) : 2'b00, 1'b0, 1'b0);
            if (k >= LAT && k - LAT < 4) check_eq("token", {22'd0, tmds_out}, tokens[k-LAT]);
        end

        // two zero pixels from blanking
        for (int k = 0; k <= LAT + 1; k++) begin
            step(8'h00, 2'b00, (k < 2), 1'b0);
            if (k == LAT) begin
                check_eq("zero1_tmds", {22'd0, tmds_out}, 'h100);
                check_eq("zero1_disp", {{27{disparity[4]}}, disparity}, -8);
            end
            if (k == LAT + 1) begin
                check_eq("zero2_tmds", {22'd0, tmds_out}, 'h3FF);
                check_eq("zero2_disp", {{27{disparity[4]}}, disparity}, 2);
            end
        end

        // single 0xFF pixel from blanking
        for (int k = 0; k < LAT + 2; k++) step(8'h00, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k <= LAT; k++) begin
            step(8'hFF, 2'b00, (k == 0), 1'b0);
            if (k == LAT) begin
                check_eq("ff_tmds", {22'd0, tmds_out}, 'h200);
                check_eq("ff_disp", {{27{disparity[4]}}, disparity}, -8);
            end
        end

        // random stream with periodic blanking and one mid-line reset
        for (int i = 0; i < 12000; i++) begin
            step(8'($urandom), 2'($urandom), ((i % 100) < 80), (i >= 6037 && i < 6040));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
